// File: rtl/alu_rs_issue_if.sv
// Allocation, common-data-bus and issue-slot signals of the ALU reservation station.
// Issue handshake: issueValid/issueSrc*/issueDest are held stable until issueValid && issueReady at a clk edge.
interface alu_rs_issue_if #(
  parameter int ALU   = 3,
  parameter int WIDTH = 31,
  parameter int TAG   = 4
);
  logic [ALU:0]   ALURequests;
  logic [WIDTH:0] allocSrc1;
  logic [WIDTH:0] allocSrc2;
  logic [TAG:0]   allocTag1;
  logic [TAG:0]   allocTag2;
  logic           allocRdy1;
  logic           allocRdy2;
  logic [TAG:0]   allocDest;
  logic           cdbValid;
  logic [TAG:0]   cdbTag;
  logic [WIDTH:0] cdbData;
  logic           issueReady;
  logic           issueValid;
  logic [WIDTH:0] issueSrc1;
  logic [WIDTH:0] issueSrc2;
  logic [TAG:0]   issueDest;
  logic [ALU:0]   ALUBusyVector;

  modport master (
    output ALURequests, allocSrc1, allocSrc2, allocTag1, allocTag2,
    output allocRdy1, allocRdy2, allocDest, cdbValid, cdbTag, cdbData, issueReady,
    input  issueValid, issueSrc1, issueSrc2, issueDest, ALUBusyVector
  );

  modport slave (
    input  ALURequests, allocSrc1, allocSrc2, allocTag1, allocTag2,
    input  allocRdy1, allocRdy2, allocDest, cdbValid, cdbTag, cdbData, issueReady,
    output issueValid, issueSrc1, issueSrc2, issueDest, ALUBusyVector
  );
endinterface

// File: rtl/alu_rs_issue.sv
// ALU reservation station: CDB wakeup, age-ordered oldest-first issue into a registered slot.
// Optional flush input enabled with macro ALU_RS_FLUSH_EN.
module alu_rs_issue #(
  parameter int ALU   = 3,
  parameter int WIDTH = 31,
  parameter int TAG   = 4
) (
  input logic clk,
  input logic reset,
`ifdef ALU_RS_FLUSH_EN
  input logic flush,
`endif
  alu_rs_issue_if.slave bus
);
  localparam int N = ALU + 1;

  logic [ALU:0]          busy_q, busy_d;
  logic [ALU:0]          rdy1_q, rdy1_d;
  logic [ALU:0]          rdy2_q, rdy2_d;
  logic [ALU:0][ALU:0]   age_q, age_d;
  logic [WIDTH:0]        src1_q [N];
  logic [WIDTH:0]        src1_d [N];
  logic [WIDTH:0]        src2_q [N];
  logic [WIDTH:0]        src2_d [N];
  logic [TAG:0]          tag1_q [N];
  logic [TAG:0]          tag1_d [N];
  logic [TAG:0]          tag2_q [N];
  logic [TAG:0]          tag2_d [N];
  logic [TAG:0]          dest_q [N];
  logic [TAG:0]          dest_d [N];

  logic                  issue_valid_q, issue_valid_d;
  logic [WIDTH:0]        issue_src1_q, issue_src1_d;
  logic [WIDTH:0]        issue_src2_q, issue_src2_d;
  logic [TAG:0]          issue_dest_q, issue_dest_d;

  logic [ALU:0]          alloc_oh;
  logic [ALU:0]          alloc_vec;
  logic [ALU:0]          eligible;
  logic [ALU:0]          issue_sel;
  logic [ALU:0]          issue_take;
  logic                  can_load;
  logic                  alloc_hit1;
  logic                  alloc_hit2;
  logic                  req_seen;

  // Lowest requested entry wins; a request that lands on a busy entry is dropped.
  always_comb begin
    alloc_oh = '0;
    req_seen = 1'b0;
    for (int i = 0; i < N; i++) begin
      alloc_oh[i] = bus.ALURequests[i] && !req_seen;
      req_seen    = req_seen || bus.ALURequests[i];
    end
    alloc_vec = alloc_oh & ~busy_q;
  end

  // age_q[i][j] set means entry i is older than entry j.
  always_comb begin
    eligible = busy_q & rdy1_q & rdy2_q;
    for (int i = 0; i < N; i++) begin
      issue_sel[i] = eligible[i];
      for (int j = 0; j < N; j++) begin
        if (j != i && eligible[j] && !age_q[i][j]) begin
          issue_sel[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    can_load      = !issue_valid_q || bus.issueReady;
    issue_take    = can_load ? issue_sel : '0;
    issue_valid_d = issue_valid_q;
    issue_src1_d  = issue_src1_q;
    issue_src2_d  = issue_src2_q;
    issue_dest_d  = issue_dest_q;
    if (can_load) begin
      issue_valid_d = |eligible;
      for (int i = 0; i < N; i++) begin
        if (issue_sel[i]) begin
          issue_src1_d = src1_q[i];
          issue_src2_d = src2_q[i];
          issue_dest_d = dest_q[i];
        end
      end
    end

    alloc_hit1 = bus.cdbValid && !bus.allocRdy1 && (bus.allocTag1 == bus.cdbTag);
    alloc_hit2 = bus.cdbValid && !bus.allocRdy2 && (bus.allocTag2 == bus.cdbTag);

    busy_d = (busy_q & ~issue_take) | alloc_vec;
    rdy1_d = rdy1_q;
    rdy2_d = rdy2_q;
    src1_d = src1_q;
    src2_d = src2_q;
    tag1_d = tag1_q;
    tag2_d = tag2_q;
    dest_d = dest_q;
    for (int i = 0; i < N; i++) begin
      if (alloc_vec[i]) begin
        src1_d[i] = alloc_hit1 ? bus.cdbData : bus.allocSrc1;
        src2_d[i] = alloc_hit2 ? bus.cdbData : bus.allocSrc2;
        rdy1_d[i] = bus.allocRdy1 || alloc_hit1;
        rdy2_d[i] = bus.allocRdy2 || alloc_hit2;
        tag1_d[i] = bus.allocTag1;
        tag2_d[i] = bus.allocTag2;
        dest_d[i] = bus.allocDest;
      end else if (busy_q[i]) begin
        if (bus.cdbValid && !rdy1_q[i] && (tag1_q[i] == bus.cdbTag)) begin
          src1_d[i] = bus.cdbData;
          rdy1_d[i] = 1'b1;
        end
        if (bus.cdbValid && !rdy2_q[i] && (tag2_q[i] == bus.cdbTag)) begin
          src2_d[i] = bus.cdbData;
          rdy2_d[i] = 1'b1;
        end
      end
    end

    // New entry becomes younger than everyone: clear its row, set its column.
    age_d = age_q;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (alloc_vec[i]) begin
          age_d[i][j] = 1'b0;
        end else if (alloc_vec[j] && (i != j)) begin
          age_d[i][j] = 1'b1;
        end
      end
    end

`ifdef ALU_RS_FLUSH_EN
    if (flush) begin
      busy_d        = '0;
      issue_valid_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_q        <= '0;
      rdy1_q        <= '0;
      rdy2_q        <= '0;
      age_q         <= '0;
      issue_valid_q <= 1'b0;
      issue_src1_q  <= '0;
      issue_src2_q  <= '0;
      issue_dest_q  <= '0;
    end else begin
      busy_q        <= busy_d;
      rdy1_q        <= rdy1_d;
      rdy2_q        <= rdy2_d;
      age_q         <= age_d;
      issue_valid_q <= issue_valid_d;
      issue_src1_q  <= issue_src1_d;
      issue_src2_q  <= issue_src2_d;
      issue_dest_q  <= issue_dest_d;
    end
  end

  // Entry payload is qualified by busy/ready, so it needs no reset.
  always_ff @(posedge clk) begin
    src1_q <= src1_d;
    src2_q <= src2_d;
    tag1_q <= tag1_d;
    tag2_q <= tag2_d;
    dest_q <= dest_d;
  end

  assign bus.issueValid    = issue_valid_q;
  assign bus.issueSrc1     = issue_src1_q;
  assign bus.issueSrc2     = issue_src2_q;
  assign bus.issueDest     = issue_dest_q;
  assign bus.ALUBusyVector = busy_q;

endmodule

// File: tb/tb_alu_rs_issue.sv
// Directed bench for alu_rs_issue: issued {src1,src2,dest} are scoreboarded against an expected queue.
module tb_alu_rs_issue;
  localparam int ALU   = 3;
  localparam int WIDTH = 31;
  localparam int TAG   = 4;
  localparam int W     = 2 * (WIDTH + 1) + TAG + 1;

  logic clk;
  logic reset;
`ifdef ALU_RS_FLUSH_EN
  logic flush;
`endif
  int checks;
  int errors;
  logic [W-1:0] exp_q[$];

  alu_rs_issue_if #(.ALU(ALU), .WIDTH(WIDTH), .TAG(TAG)) bus ();

  alu_rs_issue #(.ALU(ALU), .WIDTH(WIDTH), .TAG(TAG)) dut (
    .clk  (clk),
    .reset(reset),
`ifdef ALU_RS_FLUSH_EN
    .flush(flush),
`endif
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: at the negedge score any handshake, then step to just after the posedge.
  task automatic tick();
    logic [W-1:0] e;
    @(negedge clk);
    if (reset && bus.issueValid && bus.issueReady) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL issue_unexpected observed=%0h expected=none",
               {bus.issueSrc1, bus.issueSrc2, bus.issueDest});
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("issue_payload", {bus.issueSrc1, bus.issueSrc2, bus.issueDest}, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ALURequests = '0;
    bus.cdbValid    = 1'b0;
    bus.cdbTag      = '0;
    bus.cdbData     = '0;
    bus.allocRdy1   = 1'b0;
    bus.allocRdy2   = 1'b0;
  endtask

  task automatic alloc(input logic [ALU:0] req, input logic [WIDTH:0] s1, input logic [WIDTH:0] s2,
                       input logic [TAG:0] t1, input logic r1, input logic [TAG:0] t2,
                       input logic r2, input logic [TAG:0] d);
    bus.ALURequests = req;
    bus.allocSrc1   = s1;
    bus.allocSrc2   = s2;
    bus.allocTag1   = t1;
    bus.allocTag2   = t2;
    bus.allocRdy1   = r1;
    bus.allocRdy2   = r2;
    bus.allocDest   = d;
  endtask

  task automatic alloc_rdy(input logic [ALU:0] req, input logic [WIDTH:0] s1,
                           input logic [WIDTH:0] s2, input logic [TAG:0] d);
    alloc(req, s1, s2, '0, 1'b1, '0, 1'b1, d);
  endtask

  task automatic push(input logic [WIDTH:0] s1, input logic [WIDTH:0] s2, input logic [TAG:0] d);
    exp_q.push_back({s1, s2, d});
  endtask

  initial begin
    logic [WIDTH:0] r32;
    checks = 0;
    errors = 0;
    reset  = 1'b0;
`ifdef ALU_RS_FLUSH_EN
    flush  = 1'b0;
`endif
    idle();
    bus.allocSrc1  = '0;
    bus.allocSrc2  = '0;
    bus.allocTag1  = '0;
    bus.allocTag2  = '0;
    bus.allocDest  = '0;
    bus.issueReady = 1'b0;

    // Reset held for two cycles
    tick();
    tick();
    chk("rst_busy", bus.ALUBusyVector, 4'b0000);
    chk("rst_valid", bus.issueValid, 1'b0);
    chk("rst_slot", {bus.issueSrc1, bus.issueSrc2, bus.issueDest}, '0);
    reset = 1'b1;
    tick();

    // Fully ready entry0: issue one edge after allocation
    bus.issueReady = 1'b1;
    alloc_rdy(4'b0001, 32'd5, 32'd7, 5'd3);
    push(32'd5, 32'd7, 5'd3);
    tick();
    idle();
    chk("e0_busy", bus.ALUBusyVector, 4'b0001);
    chk("e0_not_yet", bus.issueValid, 1'b0);
    tick();
    chk("e0_valid", bus.issueValid, 1'b1);
    chk("e0_slot", {bus.issueSrc1, bus.issueSrc2, bus.issueDest}, {32'd5, 32'd7, 5'd3});
    chk("e0_busy_clear", bus.ALUBusyVector, 4'b0000);
    tick();
    chk("e0_drop", bus.issueValid, 1'b0);

    // CDB wakeup of entry2 operand 1
    alloc(4'b0100, 32'h0, 32'h11, 5'd9, 1'b0, 5'd2, 1'b1, 5'd4);
    push(32'hAA, 32'h11, 5'd4);
    tick();
    idle();
    chk("wk_busy", bus.ALUBusyVector, 4'b0100);
    chk("wk_wait", bus.issueValid, 1'b0);
    bus.cdbValid = 1'b1;
    bus.cdbTag   = 5'd9;
    bus.cdbData  = 32'hAA;
    tick();
    idle();
    chk("wk_not_same_edge", bus.issueValid, 1'b0);
    tick();
    chk("wk_valid", bus.issueValid, 1'b1);
    chk("wk_src1", bus.issueSrc1, 32'hAA);
    tick();

    // Entries 3 then 1, slot stalled for three cycles
    bus.issueReady = 1'b0;
    alloc_rdy(4'b1000, 32'h31, 32'h32, 5'd5);
    push(32'h31, 32'h32, 5'd5);
    tick();
    alloc_rdy(4'b0010, 32'h11, 32'h12, 5'd6);
    push(32'h11, 32'h12, 5'd6);
    tick();
    idle();
    chk("st_valid", bus.issueValid, 1'b1);
    chk("st_slot", {bus.issueSrc1, bus.issueSrc2, bus.issueDest}, {32'h31, 32'h32, 5'd5});
    chk("st_busy", bus.ALUBusyVector, 4'b0010);
    tick();
    tick();
    chk("st_hold", {bus.issueValid, bus.issueSrc1, bus.issueSrc2, bus.issueDest},
        {1'b1, 32'h31, 32'h32, 5'd5});
    bus.issueReady = 1'b1;
    tick();
    chk("st_next", {bus.issueValid, bus.issueSrc1, bus.issueDest}, {1'b1, 32'h11, 5'd6});
    tick();
    chk("st_drain", bus.issueValid, 1'b0);

    // Age beats index: entry3 older than entry1
    bus.issueReady = 1'b0;
    alloc_rdy(4'b0100, 32'h21, 32'h22, 5'd7);
    push(32'h21, 32'h22, 5'd7);
    tick();
    alloc_rdy(4'b1000, 32'h41, 32'h42, 5'd8);
    push(32'h41, 32'h42, 5'd8);
    tick();
    alloc_rdy(4'b0010, 32'h51, 32'h52, 5'd9);
    push(32'h51, 32'h52, 5'd9);
    tick();
    idle();
    chk("age_busy", bus.ALUBusyVector, 4'b1010);
    bus.issueReady = 1'b1;
    tick();
    chk("age_oldest", bus.issueSrc1, 32'h41);
    tick();
    chk("age_young", bus.issueSrc1, 32'h51);
    tick();

    // Multi-bit request takes lowest bit; request to busy entry ignored
    bus.issueReady = 1'b0;
    alloc_rdy(4'b0001, 32'h61, 32'h01, 5'd10);
    push(32'h61, 32'h01, 5'd10);
    tick();
    alloc_rdy(4'b0110, 32'h62, 32'h02, 5'd11);
    push(32'h62, 32'h02, 5'd11);
    tick();
    chk("mb_lowest", bus.ALUBusyVector, 4'b0010);
    alloc_rdy(4'b0010, 32'h63, 32'h03, 5'd12);
    tick();
    idle();
    chk("mb_ignored_busy", bus.ALUBusyVector, 4'b0010);
    bus.issueReady = 1'b1;
    tick();
    chk("mb_keep", bus.issueSrc1, 32'h62);
    tick();
    chk("mb_empty", {bus.issueValid, bus.ALUBusyVector}, {1'b0, 4'b0000});

    // All four entries full, allocation racing an issue
    bus.issueReady = 1'b0;
    alloc_rdy(4'b0001, 32'h71, 32'h0, 5'd13); push(32'h71, 32'h0, 5'd13); tick();
    alloc_rdy(4'b0010, 32'h72, 32'h0, 5'd14); push(32'h72, 32'h0, 5'd14); tick();
    alloc_rdy(4'b0001, 32'h73, 32'h0, 5'd15); push(32'h73, 32'h0, 5'd15); tick();
    alloc_rdy(4'b0100, 32'h74, 32'h0, 5'd16); push(32'h74, 32'h0, 5'd16); tick();
    alloc_rdy(4'b1000, 32'h75, 32'h0, 5'd17); push(32'h75, 32'h0, 5'd17); tick();
    idle();
    chk("full_busy", bus.ALUBusyVector, 4'b1111);
    chk("full_slot", bus.issueSrc1, 32'h71);
    bus.issueReady = 1'b1;
    alloc_rdy(4'b0010, 32'h76, 32'h0, 5'd18);
    push(32'h76, 32'h0, 5'd18);
    tick();
    chk("full_race_busy", bus.ALUBusyVector, 4'b1101);
    chk("full_race_slot", bus.issueSrc1, 32'h72);
    tick();
    idle();
    chk("full_realloc_busy", bus.ALUBusyVector, 4'b1110);
    chk("full_realloc_slot", bus.issueSrc1, 32'h73);
    for (int k = 0; k < 4; k++) tick();
    chk("full_drain", {bus.issueValid, bus.ALUBusyVector}, {1'b0, 4'b0000});

    // Same-cycle CDB bypass during allocation
    r32 = $urandom_range(32'h7FFF_FFFF, 0);
    alloc(4'b0001, r32, 32'h56, 5'd12, 1'b0, 5'd0, 1'b1, 5'd19);
    bus.cdbValid = 1'b1;
    bus.cdbTag   = 5'd12;
    bus.cdbData  = 32'h55;
    push(32'h55, 32'h56, 5'd19);
    tick();
    idle();
    tick();
    chk("byp_src1", {bus.issueValid, bus.issueSrc1}, {1'b1, 32'h55});
    tick();

    // Reset mid-operation discards entries and slot
    bus.issueReady = 1'b0;
    alloc_rdy(4'b0001, 32'h81, 32'h0, 5'd20); tick();
    alloc_rdy(4'b0010, 32'h82, 32'h0, 5'd21); tick();
    idle();
    reset = 1'b0;
    tick();
    chk("mrst_state", {bus.issueValid, bus.ALUBusyVector}, {1'b0, 4'b0000});
    chk("mrst_slot", {bus.issueSrc1, bus.issueSrc2, bus.issueDest}, '0);
    reset = 1'b1;
    bus.issueReady = 1'b1;
    tick();
    tick();
    chk("mrst_quiet", {bus.issueValid, bus.ALUBusyVector}, {1'b0, 4'b0000});

`ifdef ALU_RS_FLUSH_EN
    bus.issueReady = 1'b0;
    alloc_rdy(4'b0001, 32'h91, 32'h0, 5'd1); tick();
    alloc_rdy(4'b0010, 32'h92, 32'h0, 5'd2); tick();
    alloc_rdy(4'b0100, 32'h93, 32'h0, 5'd3); tick();
    alloc_rdy(4'b1000, 32'h94, 32'h0, 5'd4); tick();
    chk("fl_pre", {bus.issueValid, bus.ALUBusyVector}, {1'b1, 4'b1110});
    alloc_rdy(4'b0001, 32'h95, 32'h0, 5'd5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    chk("fl_post", {bus.issueValid, bus.ALUBusyVector}, {1'b0, 4'b0000});
    bus.issueReady = 1'b1;
    tick();
`endif

    tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
